// File: rtl/data_request_rx.sv
// rtl/data_request_rx.sv - sends 0xFF request, reassembles 16-bit channel words from the reply, sends 0x00 release
// Built-in 8N1 UART. Define DATA_REQ_TIMEOUT_EN to compile in the inter-byte timeout abort.
module data_request_rx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int NUM_CH         = 16,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        START,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] CH_DATA,
  output logic [3:0]  CH_IDX,
  output logic        CH_VALID,
  output logic        FRAME_DONE,
  output logic        ERR,
  output logic        BUSY
);
  localparam int BCW = $clog2(CLKS_PER_BIT + 1);
  localparam int WCW = $clog2(NUM_CH + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, SEND_REQ, RECV_LO, RECV_HI, SEND_REL} state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [WCW-1:0]   cnt_q, cnt_d;
  logic [7:0]       lo_q, lo_d;
  logic [15:0]      ch_data_q, ch_data_d;
  logic [3:0]       ch_idx_q, ch_idx_d;
  logic             ch_valid_q, ch_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;

  logic             tx_q, tx_d, tx_active_q, tx_active_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [BCW-1:0]   tx_cnt_q, tx_cnt_d;
  logic             tx_load, tx_done;
  logic [7:0]       tx_data;

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic             rx_active_q, rx_active_d;
  logic [BCW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_start_edge, rx_sample, rx_done, rx_ferr;
  logic             timeout;

  assign tx_done       = tx_active_q && (tx_cnt_q == BIT_LAST) && (tx_bit_q == 4'd9);
  assign rx_start_edge = !rx_active_q && rx_prev_q && !rx_s2_q;
  assign rx_sample     = rx_active_q && (rx_cnt_q == ((rx_bit_q == 4'd0) ? HALF_LAST : BIT_LAST));
  assign rx_done       = rx_sample && (rx_bit_q == 4'd9);
  assign rx_ferr       = !rx_s2_q;

  // tx_q is the shift-out register; the frame holds {stop, data} behind the start bit
  always_comb begin
    tx_d        = tx_q;
    tx_active_d = tx_active_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    if (tx_load) begin
      tx_d        = 1'b0;
      tx_active_d = 1'b1;
      tx_shift_d  = {1'b1, tx_data};
      tx_bit_d    = 4'd0;
      tx_cnt_d    = '0;
    end else if (tx_active_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_active_d = 1'b0;
        end else begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + BCW'(1);
      end
    end
  end

  // Sample index 0 is the mid-start check, 1..8 data, 9 the stop bit
  always_comb begin
    rx_active_d = rx_active_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    if (rx_start_edge) begin
      rx_active_d = 1'b1;
      rx_cnt_d    = '0;
      rx_bit_d    = 4'd0;
    end else if (rx_active_q) begin
      if (rx_sample) begin
        rx_cnt_d = '0;
        if (rx_bit_q == 4'd0) begin
          if (rx_s2_q) rx_active_d = 1'b0;
          else         rx_bit_d    = 4'd1;
        end else if (rx_bit_q == 4'd9) begin
          rx_active_d = 1'b0;
        end else begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + BCW'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    ch_data_d    = ch_data_q;
    ch_idx_d     = ch_idx_q;
    ch_valid_d   = 1'b0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    tx_load      = 1'b0;
    tx_data      = 8'h00;
    case (state_q)
      IDLE: if (START) begin
        tx_load = 1'b1;
        tx_data = 8'hFF;
        cnt_d   = '0;
        done_d  = 1'b0;
        state_d = SEND_REQ;
      end
      SEND_REQ: if (tx_done) state_d = RECV_LO;
      RECV_LO, RECV_HI: begin
        if ((rx_done && rx_ferr) || (!rx_done && timeout)) begin
          done_d  = 1'b0;
          tx_load = 1'b1;
          state_d = SEND_REL;
        end else if (rx_done && state_q == RECV_LO) begin
          lo_d    = rx_shift_q;
          state_d = RECV_HI;
        end else if (rx_done) begin
          ch_data_d  = {rx_shift_q, lo_q};
          ch_idx_d   = 4'(cnt_q);
          ch_valid_d = 1'b1;
          cnt_d      = cnt_q + WCW'(1);
          if (cnt_q == WCW'(NUM_CH - 1)) begin
            done_d  = 1'b1;
            tx_load = 1'b1;
            state_d = SEND_REL;
          end else begin
            state_d = RECV_LO;
          end
        end
      end
      SEND_REL: if (tx_done) begin
        frame_done_d = done_q;
        err_d        = !done_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DATA_REQ_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           in_recv;

  assign in_recv = (state_q == RECV_LO) || (state_q == RECV_HI);
  assign timeout = in_recv && (to_cnt_q == TCW'(TIMEOUT_CYCLES));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d == RECV_LO && state_q != RECV_LO) || rx_start_edge) to_cnt_d = '0;
    else if (in_recv && !timeout) to_cnt_d = to_cnt_q + TCW'(1);
  end

  always_ff @(posedge CLK_50M) begin
    if (RESET) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state_q      <= IDLE;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      lo_q         <= '0;
      ch_data_q    <= '0;
      ch_idx_q     <= '0;
      ch_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      tx_q         <= 1'b1;
      tx_active_q  <= 1'b0;
      tx_shift_q   <= '1;
      tx_bit_q     <= '0;
      tx_cnt_q     <= '0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_active_q  <= 1'b0;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      ch_data_q    <= ch_data_d;
      ch_idx_q     <= ch_idx_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      tx_q         <= tx_d;
      tx_active_q  <= tx_active_d;
      tx_shift_q   <= tx_shift_d;
      tx_bit_q     <= tx_bit_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_s1_q      <= RX;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_active_q  <= rx_active_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
    end
  end

  assign TX         = tx_q;
  assign CH_DATA    = ch_data_q;
  assign CH_IDX     = ch_idx_q;
  assign CH_VALID   = ch_valid_q;
  assign FRAME_DONE = frame_done_q;
  assign ERR        = err_q;
  assign BUSY       = (state_q != IDLE);
endmodule

// File: tb/tb_data_request_rx.sv
// tb/tb_data_request_rx.sv - scenario-table bench with responder model, TX decoder and word scoreboard
module tb_data_request_rx;
  localparam int CPB = 4;
  localparam int NCH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic [15:0] ch_data;
  logic [3:0]  ch_idx;
  logic        ch_valid, frame_done, err, busy;

  data_request_rx #(.CLKS_PER_BIT(CPB), .NUM_CH(NCH), .TIMEOUT_CYCLES(200)) dut (
    .CLK_50M(clk), .RESET(reset), .START(start), .RX(rx), .TX(tx),
    .CH_DATA(ch_data), .CH_IDX(ch_idx), .CH_VALID(ch_valid),
    .FRAME_DONE(frame_done), .ERR(err), .BUSY(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] idx; logic [15:0] data; } sb_t;
  typedef struct {
    string name; int n_good; bit bad; int pause; int n_rest;
    logic [15:0] base; logic [15:0] step;
    int exp_valid; bit exp_done; bit exp_err;
  } scen_t;

  sb_t        sb[$];
  logic [7:0] tx_log[$];
  scen_t      tbl[$];
  int n_checks = 0, n_fail = 0;
  int n_valid = 0, n_done = 0, n_err = 0, bad_pulse = 0, txm_bad = 0;
  bit txm_active = 1'b0;
  int txm_cnt = 0;
  logic [7:0] txm_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of observation: scoreboard pops, pulse counting and TX byte decoding
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (ch_valid) begin
      n_valid++;
      if (sb.size() == 0) check("sb_unexpected_valid", 32'(ch_idx), 32'hFFFF);
      else begin
        e = sb.pop_front();
        check("ch_idx", 32'(ch_idx), 32'(e.idx));
        check("ch_data", 32'(ch_data), 32'(e.data));
      end
    end
    if (frame_done) n_done++;
    if (err) n_err++;
    if ((frame_done || err) && busy) bad_pulse++;
    if (!txm_active) begin
      if (!tx) begin txm_active = 1'b1; txm_cnt = 0; end
    end else begin
      txm_cnt++;
      for (int i = 0; i < 8; i++) if (txm_cnt == CPB/2 + CPB*(i+1)) txm_byte[i] = tx;
      if (txm_cnt == CPB/2 + CPB*9) begin
        if (!tx) txm_bad++;
        tx_log.push_back(txm_byte);
        txm_active = 1'b0;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0; repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (CPB) tick(); end
    rx = stop_ok; repeat (CPB) tick();
    rx = 1'b1; repeat (3) tick();
  endtask

  task automatic send_idx(input int idx, input logic [15:0] base, input logic [15:0] step, input logic ok);
    logic [15:0] w;
    sb_t e;
    w = base + 16'(idx / 2) * step;
    if ((idx % 2 == 1) && ok) begin
      e.idx = 4'(idx / 2); e.data = w;
      sb.push_back(e);
    end
    send_byte((idx % 2 == 1) ? w[15:8] : w[7:0], ok);
  endtask

  task automatic wait_request(input int base_tx);
    for (int i = 0; i < 200 && tx_log.size() == base_tx; i++) tick();
    check("req_byte_count", 32'(tx_log.size() - base_tx), 1);
    if (tx_log.size() > base_tx) check("req_byte_value", 32'(tx_log[base_tx]), 32'hFF);
    repeat (8) tick();
  endtask

  task automatic run_scenario(input scen_t v);
    int base_tx, base_valid, base_done, base_err, b;
    logic [15:0] last_w;
    base_tx = tx_log.size(); base_valid = n_valid; base_done = n_done; base_err = n_err;
    start = 1'b1; tick(); start = 1'b0;
    wait_request(base_tx);
    b = 0;
    for (int i = 0; i < v.n_good; i++) begin send_idx(b, v.base, v.step, 1'b1); b++; end
    if (v.bad) begin send_idx(b, v.base, v.step, 1'b0); b++; end
    if (v.pause > 0) begin
      repeat (v.pause) tick();
      check({v.name, "_busy_hold"}, 32'(busy), 1);
      check({v.name, "_no_err_hold"}, 32'(n_err - base_err), 0);
      for (int i = 0; i < v.n_rest; i++) begin send_idx(b, v.base, v.step, 1'b1); b++; end
    end
    for (int i = 0; i < 2000 && busy; i++) tick();
    check({v.name, "_busy_fall"}, 32'(busy), 0);
    repeat (5) tick();
    check({v.name, "_valid_count"}, 32'(n_valid - base_valid), 32'(v.exp_valid));
    check({v.name, "_frame_done"}, 32'(n_done - base_done), 32'(v.exp_done));
    check({v.name, "_err"}, 32'(n_err - base_err), 32'(v.exp_err));
    check({v.name, "_tx_bytes"}, 32'(tx_log.size() - base_tx), 2);
    if (tx_log.size() >= base_tx + 2) check({v.name, "_release_byte"}, 32'(tx_log[base_tx+1]), 32'h00);
    check({v.name, "_sb_empty"}, 32'(sb.size()), 0);
    if (v.exp_done) begin
      last_w = v.base + 16'(NCH - 1) * v.step;
      check({v.name, "_hold_idx"}, 32'(ch_idx), 32'(NCH - 1));
      check({v.name, "_hold_data"}, 32'(ch_data), 32'(last_w));
    end
    sb.delete();
  endtask

  initial begin
    int base_tx, base_valid, base_done, base_err, lows;
    tbl.push_back('{"normal",  32, 1'b0, 0, 0, 16'h1200, 16'h0001, 16, 1'b1, 1'b0});
    tbl.push_back('{"pattern", 32, 1'b0, 0, 0, 16'hFF00, 16'h0111, 16, 1'b1, 1'b0});
    tbl.push_back('{"framing",  2, 1'b1, 0, 0, 16'h3400, 16'h0001,  1, 1'b0, 1'b1});
`ifdef DATA_REQ_TIMEOUT_EN
    tbl.push_back('{"timeout",  5, 1'b0, 0, 0, 16'h5600, 16'h0001,  2, 1'b0, 1'b1});
`else
    tbl.push_back('{"no_timeout", 5, 1'b0, 2000, 27, 16'h5600, 16'h0001, 16, 1'b1, 1'b0});
`endif

    repeat (3) tick();
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(ch_valid), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_data", 32'(ch_data), 0);
    check("rst_idx", 32'(ch_idx), 0);
    reset = 1'b0;
    repeat (3) tick();

    // Request waveform, with a second START dropped in while busy
    base_tx = tx_log.size(); base_valid = n_valid; base_done = n_done; base_err = n_err;
    start = 1'b1;
    for (int k = 1; k <= 10*CPB; k++) begin
      tick();
      if (k == 1) begin start = 1'b0; check("req_busy_rise", 32'(busy), 1); end
      check($sformatf("req_tx_cycle_%0d", k), 32'(tx), (k <= CPB) ? 32'd0 : 32'd1);
      if (k == 9) start = 1'b1;
      if (k == 10) start = 1'b0;
    end
    wait_request(base_tx);
    for (int i = 0; i < 3; i++) send_idx(i, 16'h7700, 16'h0001, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_busy", 32'(busy), 0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (!tx) lows++; end
    check("rst_mid_tx_quiet", 32'(lows), 0);
    check("rst_mid_one_request", 32'(tx_log.size() - base_tx), 1);
    check("rst_mid_valids", 32'(n_valid - base_valid), 1);
    check("rst_mid_no_done", 32'(n_done - base_done), 0);
    check("rst_mid_no_err", 32'(n_err - base_err), 0);
    sb.delete();

    reset = 1'b1; start = 1'b1; tick();
    reset = 1'b0; start = 1'b0; tick();
    check("start_with_reset_ignored", 32'(busy), 0);
    repeat (3) tick();

    for (int s = 0; s < tbl.size(); s++) begin
      run_scenario(tbl[s]);
      repeat (4) tick();
    end

    check("pulse_while_busy", 32'(bad_pulse), 0);
    check("tx_stop_bits", 32'(txm_bad), 0);
    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end
endmodule
